// File: rtl/neural_net_pkg.sv
// neural_net_pkg: shared sizing, FSM state type and fixed-point helpers for the MLP engine.
// Define NN_SAT_EN to make requantization saturate instead of wrapping.
package neural_net_pkg;

    localparam int NN_N_IN   = 4;
    localparam int NN_N_HID  = 4;
    localparam int NN_N_OUT  = 2;
    localparam int NN_DATA_W = 8;
    localparam int NN_FRAC_W = 4;
    localparam int NN_ACC_W  = 20;

    function automatic int nn_hb(int n_in, int n_hid);
        return n_hid * (n_in + 1);
    endfunction

    function automatic int nn_depth(int n_in, int n_hid, int n_out);
        return nn_hb(n_in, n_hid) + n_out * (n_hid + 1);
    endfunction

    localparam int NN_HB    = nn_hb(NN_N_IN, NN_N_HID);
    localparam int NN_DEPTH = NN_HB + NN_N_OUT * (NN_N_HID + 1);
    localparam int NN_AW    = $clog2(NN_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HID,
        ST_OUT,
        ST_DONE
    } nn_state_e;

    typedef logic signed [NN_DATA_W-1:0] nn_data_t;
    typedef logic signed [NN_ACC_W-1:0]  nn_acc_t;

`ifdef NN_SAT_EN
    localparam nn_acc_t NN_SAT_HI = nn_acc_t'(2 ** (NN_DATA_W - 1) - 1);
    localparam nn_acc_t NN_SAT_LO = nn_acc_t'(-(2 ** (NN_DATA_W - 1)));
`endif

    function automatic nn_data_t nn_requant(nn_acc_t s);
        nn_acc_t sh;
        sh = s >>> NN_FRAC_W;
`ifdef NN_SAT_EN
        if (sh > NN_SAT_HI) begin
            return NN_SAT_HI[NN_DATA_W-1:0];
        end
        if (sh < NN_SAT_LO) begin
            return NN_SAT_LO[NN_DATA_W-1:0];
        end
        return sh[NN_DATA_W-1:0];
`else
        return sh[NN_DATA_W-1:0];
`endif
    endfunction

    function automatic nn_data_t nn_relu(nn_data_t v);
        return v[NN_DATA_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/neural_net_if.sv
// neural_net_if: parameter-write, start and result bundle of the MLP engine.
// The master side loads parameters and starts runs; the slave side is the engine.
interface neural_net_if #(
    parameter int N_IN   = neural_net_pkg::NN_N_IN,
    parameter int N_OUT  = neural_net_pkg::NN_N_OUT,
    parameter int DATA_W = neural_net_pkg::NN_DATA_W,
    parameter int AW     = neural_net_pkg::NN_AW,
    parameter int CLW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
);

    logic                     wr_en_i;
    logic [AW-1:0]            wr_addr_i;
    logic signed [DATA_W-1:0] wr_data_i;
    logic                     start_i;
    logic [N_IN*DATA_W-1:0]   x_i;
    logic                     busy_o;
    logic                     done_o;
    logic [N_OUT*DATA_W-1:0]  y_o;
    logic [CLW-1:0]           class_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, start_i, x_i,
        input  busy_o, done_o, y_o, class_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, start_i, x_i,
        output busy_o, done_o, y_o, class_o
    );

endinterface

// File: rtl/neural_net_mac.sv
// nn_mac: shared signed multiply-accumulate with bias preload and requantized
// view of the running sum including the current product.
module nn_mac
    import neural_net_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int FRAC_W = NN_FRAC_W,
    parameter int ACC_W  = NN_ACC_W
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     clr_i,
    input  logic                     load_i,
    input  logic                     acc_en_i,
    input  logic signed [DATA_W-1:0] bias_i,
    input  logic signed [DATA_W-1:0] w_i,
    input  logic signed [DATA_W-1:0] a_i,
    output logic signed [DATA_W-1:0] q_o
);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    sum;
    logic signed [2*DATA_W-1:0] prod;

    assign prod = w_i * a_i;
    assign sum  = acc_q + ACC_W'(prod);
    assign q_o  = nn_requant(sum);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = ACC_W'(bias_i) <<< FRAC_W;
        end else if (acc_en_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/neural_net_top.sv
// neural_net_top: 2-layer fixed-point MLP (ReLU hidden, linear output, argmax)
// on one time-shared MAC. Define NN_SAT_EN for saturating requantization.
module neural_net_top
    import neural_net_pkg::*;
#(
    parameter int N_IN   = NN_N_IN,
    parameter int N_HID  = NN_N_HID,
    parameter int N_OUT  = NN_N_OUT,
    parameter int DATA_W = NN_DATA_W,
    parameter int FRAC_W = NN_FRAC_W,
    parameter int ACC_W  = NN_ACC_W
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    neural_net_if.slave bus
);

    localparam int HB    = nn_hb(N_IN, N_HID);
    localparam int DEPTH = nn_depth(N_IN, N_HID, N_OUT);
    localparam int AW    = $clog2(DEPTH);
    localparam int CLW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW    = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
    localparam int NMAX  = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int NW    = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int XW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int HW    = (N_HID > 1) ? $clog2(N_HID) : 1;

    nn_state_e               state_q;
    logic [KW-1:0]           k_q;
    logic [NW-1:0]           n_q;
    logic                    busy_q;
    logic                    done_q;
    logic [N_OUT*DATA_W-1:0] y_q;
    logic [CLW-1:0]          class_q;

    logic signed [DATA_W-1:0] prm_q [DEPTH];
    logic signed [DATA_W-1:0] x_q   [N_IN];
    logic signed [DATA_W-1:0] hid_q [N_HID];
    logic signed [DATA_W-1:0] yw_q  [N_OUT];

    logic                     in_hid;
    logic                     mac_on;
    logic                     ready;
    logic                     start_ok;
    logic                     wr_ok;
    logic                     last_k;
    logic                     last_n;
    logic [KW-1:0]            fan;
    logic [KW-1:0]            aidx;
    logic [AW-1:0]            rd_addr;
    logic signed [DATA_W-1:0] w;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] y_sel [N_OUT];
    logic [N_OUT*DATA_W-1:0]  y_d;
    logic [CLW-1:0]           class_d;

    assign in_hid   = (state_q == ST_HID);
    assign mac_on   = in_hid || (state_q == ST_OUT);
    assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_ok = ready && bus.start_i;
    assign wr_ok    = ready && bus.wr_en_i
                   && ({1'b0, bus.wr_addr_i} < (AW + 1)'(DEPTH));

    assign fan    = in_hid ? KW'(N_IN) : KW'(N_HID);
    assign last_k = (k_q == fan);
    assign last_n = in_hid ? (n_q == NW'(N_HID - 1))
                           : (n_q == NW'(N_OUT - 1));
    assign aidx   = (k_q == '0) ? '0 : k_q - KW'(1);

    // Step 0 fetches the bias slot; step k fetches weight k-1.
    always_comb begin
        rd_addr = in_hid ? AW'(int'(n_q) * (N_IN + 1))
                         : AW'(HB + int'(n_q) * (N_HID + 1));
        rd_addr = rd_addr + ((k_q == '0) ? AW'(fan) : AW'(aidx));
    end

    assign w = prm_q[rd_addr];
    assign a = in_hid ? x_q[XW'(aidx)] : hid_q[HW'(aidx)];

    nn_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr_i    (start_ok),
        .load_i   (mac_on && (k_q == '0)),
        .acc_en_i (mac_on && (k_q != '0)),
        .bias_i   (w),
        .w_i      (w),
        .a_i      (a),
        .q_o      (q)
    );

    always_comb begin
        y_d     = '0;
        class_d = '0;
        for (int o = 0; o < N_OUT; o++) begin
            y_sel[o] = (NW'(o) == n_q) ? q : yw_q[o];
            y_d[o*DATA_W +: DATA_W] = y_sel[o];
        end
        for (int o = 1; o < N_OUT; o++) begin
            if (y_sel[o] > y_sel[class_d]) begin
                class_d = CLW'(o);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            class_q <= '0;
            for (int i = 0; i < DEPTH; i++) prm_q[i] <= '0;
            for (int i = 0; i < N_IN; i++)  x_q[i]   <= '0;
            for (int i = 0; i < N_HID; i++) hid_q[i] <= '0;
            for (int i = 0; i < N_OUT; i++) yw_q[i]  <= '0;
        end else begin
            done_q <= 1'b0;
            if (wr_ok) begin
                prm_q[bus.wr_addr_i] <= bus.wr_data_i;
            end
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (bus.start_i) begin
                        state_q <= ST_HID;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        n_q     <= '0;
                        for (int i = 0; i < N_IN; i++) begin
                            x_q[i] <= bus.x_i[i*DATA_W +: DATA_W];
                        end
                    end
                end
                ST_HID: begin
                    k_q <= last_k ? '0 : k_q + KW'(1);
                    if (last_k) begin
                        hid_q[HW'(n_q)] <= nn_relu(q);
                        n_q <= last_n ? '0 : n_q + NW'(1);
                        if (last_n) begin
                            state_q <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    k_q <= last_k ? '0 : k_q + KW'(1);
                    if (last_k) begin
                        yw_q[CLW'(n_q)] <= q;
                        n_q <= last_n ? '0 : n_q + NW'(1);
                        if (last_n) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            y_q     <= y_d;
                            class_q <= class_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.y_o     = y_q;
    assign bus.class_o = class_q;

endmodule

// File: tb/tb_neural_net_top.sv
// tb_neural_net_top: directed and randomized runs of the MLP engine checked
// against an integer reference model of the network.
module tb_neural_net_top;

    localparam int NI  = 4;
    localparam int NH  = 4;
    localparam int NO  = 2;
    localparam int HBA = NH * (NI + 1);
    localparam int DEP = HBA + NO * (NH + 1);
    localparam int LAT = DEP + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    neural_net_if bus ();

    neural_net_top dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;
    int prm [DEP];
    int xv  [NI];
    int ey  [NO];
    int ecls;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sx8(int v);
        int r;
        r = v & 255;
        if (r > 127) r -= 256;
        return r;
    endfunction

    // Floor-divide by 2^FRAC, then fit into 8 bits.
    function automatic int rq(int s);
        int sh;
        sh = (s >= 0) ? s / 16 : -((-s + 15) / 16);
`ifdef NN_SAT_EN
        if (sh > 127) sh = 127;
        if (sh < -128) sh = -128;
        return sh;
`else
        return sx8(sh);
`endif
    endfunction

    task automatic model();
        int hv [NH];
        int s;
        for (int h = 0; h < NH; h++) begin
            s = prm[h*(NI+1) + NI] * 16;
            for (int i = 0; i < NI; i++) s += prm[h*(NI+1) + i] * xv[i];
            hv[h] = rq(s);
            if (hv[h] < 0) hv[h] = 0;
        end
        for (int o = 0; o < NO; o++) begin
            s = prm[HBA + o*(NH+1) + NH] * 16;
            for (int j = 0; j < NH; j++) s += prm[HBA + o*(NH+1) + j] * hv[j];
            ey[o] = rq(s);
        end
        ecls = 0;
        for (int o = 1; o < NO; o++) if (ey[o] > ey[ecls]) ecls = o;
    endtask

    task automatic wr(int addr, int val);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 5'(addr);
        bus.wr_data_i = 8'(val);
        @(negedge clk);
        bus.wr_en_i = 1'b0;
        if (addr < DEP) prm[addr] = sx8(val);
    endtask

    task automatic clear_all();
        for (int a = 0; a < DEP; a++) wr(a, 0);
    endtask

    task automatic drive_x();
        for (int k = 0; k < NI; k++) bus.x_i[k*8 +: 8] = 8'(xv[k]);
    endtask

    task automatic rand_x();
        for (int k = 0; k < NI; k++) xv[k] = sx8(int'($urandom_range(0, 255)));
    endtask

    task automatic run(string tag, bit prot);
        int cyc;
        logic [7:0] e8;
        model();
        drive_x();
        bus.start_i = 1'b1;
        @(negedge clk);
        cyc = 1;
        bus.start_i = 1'b0;
        check({tag, ".busy"}, 32'(bus.busy_o), 32'd1);
        while (bus.done_o !== 1'b1 && cyc < 64) begin
            if (prot && cyc == 10) begin
                bus.start_i   = 1'b1;
                bus.wr_en_i   = 1'b1;
                bus.wr_addr_i = 5'd0;
                bus.wr_data_i = 8'h55;
                bus.x_i       = $urandom;
            end
            @(negedge clk);
            cyc++;
            bus.start_i = 1'b0;
            bus.wr_en_i = 1'b0;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(LAT));
        for (int o = 0; o < NO; o++) begin
            e8 = 8'(ey[o]);
            check($sformatf("%s.y%0d", tag, o), 32'(bus.y_o[o*8 +: 8]), 32'(e8));
        end
        check({tag, ".class"}, 32'(bus.class_o), 32'(ecls));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done_o), 32'd0);
        e8 = 8'(ey[0]);
        check({tag, ".y0_hold"}, 32'(bus.y_o[7:0]), 32'(e8));
    endtask

    initial begin
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.start_i   = 1'b0;
        bus.x_i       = '0;
        for (int a = 0; a < DEP; a++) prm[a] = 0;
        for (int k = 0; k < NI; k++) xv[k] = 0;

        repeat (3) @(negedge clk);
        check("rst.busy", 32'(bus.busy_o), 32'd0);
        check("rst.done", 32'(bus.done_o), 32'd0);
        check("rst.y", 32'(bus.y_o), 32'd0);
        check("rst.class", 32'(bus.class_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        rand_x();
        run("zero", 1'b0);

        wr(HBA + 1*(NH+1) + NH, 16);
        rand_x();
        run("bias", 1'b0);
        check("bias.y1_const", 32'(bus.y_o[15:8]), 32'd16);

        wr(HBA + 1*(NH+1) + NH, 0);
        wr(0, 16);
        wr(HBA, 16);
        xv = '{32, 0, 0, 0};
        run("pass", 1'b0);
        check("pass.y0_const", 32'(bus.y_o[7:0]), 32'd32);

        drive_x();
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("abort.busy_before", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy_o), 32'd0);
        check("abort.y", 32'(bus.y_o), 32'd0);
        check("abort.done", 32'(bus.done_o), 32'd0);
        check("abort.class", 32'(bus.class_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < DEP; a++) prm[a] = 0;
        @(negedge clk);

        rand_x();
        run("cleared", 1'b0);

        for (int h = 0; h < NH; h++) wr(h*(NI+1) + NI, -16);
        for (int o = 0; o < NO; o++)
            for (int j = 0; j < NH; j++) wr(HBA + o*(NH+1) + j, 16);
        xv = '{0, 0, 0, 0};
        run("relu_tie", 1'b0);

        clear_all();
        for (int h = 0; h < NH; h++)
            for (int i = 0; i < NI; i++) wr(h*(NI+1) + i, 127);
        wr(HBA, 16);
        xv = '{127, 127, 127, 127};
        run("ovf", 1'b0);
`ifdef NN_SAT_EN
        check("ovf.y0_const", 32'(bus.y_o[7:0]), 32'd127);
`else
        check("ovf.y0_const", 32'(bus.y_o[7:0]), 32'd0);
`endif

        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < DEP; a++) wr(a, int'($urandom_range(0, 255)));
            rand_x();
            run($sformatf("rnd%0d", t), 1'b0);
        end

        for (int a = 0; a < DEP; a++) wr(a, int'($urandom_range(0, 63)) - 32);
        wr(DEP, 99);
        wr(DEP + 1, 99);
        rand_x();
        run("prot", 1'b1);
        rand_x();
        run("after_prot", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neural_net_top.md
Name: neural_net_top

Overview:
- Self-contained fixed-point inference engine for a 2-layer fully connected perceptron: input → ReLU hidden layer → linear output layer → argmax class.
- Weights and biases are held in an internal register file loaded through a write port.
- One time-multiplexed signed MAC unit evaluates all neurons sequentially.
- Top-level compute block of the neural_network subsystem.

Parameters:
- N_IN, 4, input vector length.
- N_HID, 4, hidden neurons.
- N_OUT, 2, output neurons.
- DATA_W, 8, signed width of inputs, weights, biases and activations.
- FRAC_W, 4, fractional bits (Q4.4 default).
- ACC_W, 20, signed accumulator width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- wr_en_i  in  1  weight/bias write strobe.
- wr_addr_i  in  $clog2(N_HID*(N_IN+1)+N_OUT*(N_HID+1))  parameter address.
- wr_data_i  in  DATA_W  signed parameter value.
- start_i  in  1  begin inference, sampling x_i.
- x_i  in  N_IN*DATA_W  packed signed inputs; element k is at bits [k*DATA_W +: DATA_W].
- busy_o  out  1  computation in progress.
- done_o  out  1  one-cycle completion pulse.
- y_o  out  N_OUT*DATA_W  packed signed outputs.
- class_o  out  $clog2(N_OUT) (min 1)  argmax index.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; busy_o=0, done_o=0, y_o=0, class_o=0; hidden regs=0; parameter file=0.
- Parameter map:
  - Hidden neuron h occupies addresses h*(N_IN+1)+i; i<N_IN is a weight, i=N_IN is the bias.
  - Output neuron o occupies base HB=N_HID*(N_IN+1) plus o*(N_HID+1)+j; j=N_HID is the bias.
  - Writes are honoured only in IDLE/DONE and ignored while busy.
  - Out-of-range addresses are ignored.
- FSM states: IDLE → HID → OUT → DONE → IDLE.
  - In IDLE or DONE, start_i latches x_i and enters HID. start_i is ignored while busy.
  - DONE lasts one cycle: done_o=1, and y_o/class_o are updated in the same cycle.
  - y_o and class_o then hold until the next DONE.
- Per-neuron timing: fan_in+1 cycles.
  - Cycle 0: acc = sign-extended bias <<< FRAC_W.
  - Cycles 1..fan_in: acc += w*a, a full-precision signed product.
  - On the last MAC cycle the final sum is requantized: arithmetic shift right by FRAC_W, then fitted to DATA_W.
- Hidden results pass through ReLU (negative → 0). Output results are linear.
- Latency from the start_i cycle to the done_o cycle is N_HID*(N_IN+1)+N_OUT*(N_HID+1)+1, which is 31 at defaults. busy_o is high throughout HID and OUT.
- Argmax: largest signed y; a tie selects the lowest index.
- Reset asserted mid-operation aborts immediately to reset values.

Optional Feature:
- NN_SAT_EN defined: requantization saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: requantization keeps the low DATA_W bits (two's-complement wrap).

Decomposition:
- Package neural_net_pkg holds:
  - FSM state enum (IDLE, HID, OUT, DONE);
  - localparams for parameter-file depth, HB base and address width;
  - requantize/ReLU functions.
- One sub-module: nn_mac, the signed MAC with accumulator clear/load-bias/accumulate controls and the requantize output.

Test Plan:
- Reset: hold reset_ni=0 → busy_o=0, done_o=0, y_o=0, class_o=0. Then release, start with all parameters 0 → after 31 cycles done_o=1, y=(0,0), class 0.
- Bias only: output-1 bias=16 (1.0), rest 0 → y0=0, y1=16, class_o=1, done_o exactly 31 cycles after start.
- Pass-through:
  - Setup: w_hid[0][0]=16, w_out[0][0]=16, x0=32, other parameters 0.
  - Required: y0=32, y1=0, class_o=0.
- ReLU and tie:
  - Setup: all hidden biases=-16, all output weights=16, output biases 0, x=0.
  - Required: y=(0,0), class_o=0.
- Overflow: all x=127, all hidden weights=127, w_out[0][0]=16.
  - With NN_SAT_EN: h0=127 and y0=127.
  - Without NN_SAT_EN: h0=-64 → ReLU 0 → y0=0.
- Protocol: start_i and wr_en_i pulsed mid-run are ignored, and done_o stays on schedule. Dropping reset_ni mid-run gives busy_o=0 and y_o=0 at once.
